// File: rtl/eprisc_uart_pkg.sv
// Shared types and constants for the epRISC UART receive path.
package eprisc_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/eprisc_uart_rx_fifo.sv
// Receive buffer for the UART receiver: push side from the deframer,
// valid/ready pop side toward the command decoder. oData/oValid are registered.
// Build option: UART_RX_FIFO_EN selects a circular FIFO of DEPTH entries;
// without it the buffer is a single holding register with the same handshake.
module eprisc_uart_rx_fifo
    import eprisc_uart_pkg::*;
`ifdef UART_RX_FIFO_EN
#(
    parameter int DEPTH = 4
)
`endif
(
    input  logic                      iBoardClock,
    input  logic                      iBoardReset,
    input  logic                      iPush,
    input  logic [UART_DATA_BITS-1:0] iPushData,
    output logic [UART_DATA_BITS-1:0] oData,
    output logic                      oValid,
    input  logic                      iReady,
    output logic                      oDrop
);

    logic pop;
    logic full;
    logic pushAccepted;

    // A pop in the same cycle frees the slot a full-buffer push needs.
    assign pop          = oValid && iReady;
    assign pushAccepted = iPush && (!full || pop);
    assign oDrop        = iPush && full && !pop;

`ifdef UART_RX_FIFO_EN

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]             wrPtr;
    logic [PW-1:0]             rdPtr;
    logic [PW-1:0]             wrPtrNext;
    logic [PW-1:0]             rdPtrNext;

    // Pointer MSB acts as a lap bit: equal pointers mean empty, a full lap apart means full.
    assign full = (wrPtr - rdPtr) == PW'(DEPTH);

    // Pointer advance for this cycle's accepted push and pop.
    always_comb begin
        wrPtrNext = wrPtr + PW'(pushAccepted);
        rdPtrNext = rdPtr + PW'(pop);
    end

    // Storage write.
    // NOTE: the array has no reset; an entry is only read after it has been written.
    always_ff @(posedge iBoardClock) begin
        if (pushAccepted) begin
            mem[wrPtr[AW-1:0]] <= iPushData;
        end
    end

    // Pointers and the registered head entry; the byte being written this
    // cycle is forwarded when it becomes the new head.
    always_ff @(posedge iBoardClock) begin
        if (iBoardReset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            oValid <= 1'b0;
            oData  <= '0;
        end else begin
            wrPtr  <= wrPtrNext;
            rdPtr  <= rdPtrNext;
            oValid <= (wrPtrNext != rdPtrNext);
            if (pushAccepted && (rdPtrNext == wrPtr)) begin
                oData <= iPushData;
            end else if (wrPtrNext != rdPtrNext) begin
                oData <= mem[rdPtrNext[AW-1:0]];
            end
        end
    end

`else

    assign full = oValid;

    // Single holding register: a push refills it, a lone pop empties it.
    always_ff @(posedge iBoardClock) begin
        if (iBoardReset) begin
            oValid <= 1'b0;
            oData  <= '0;
        end else if (pushAccepted) begin
            oValid <= 1'b1;
            oData  <= iPushData;
        end else if (pop) begin
            oValid <= 1'b0;
        end
    end

`endif

endmodule

// File: rtl/eprisc_uart_receiver.sv
// 8N1 serial receiver for the epRISC I/O controller: synchronizes the RX pin,
// deframes bytes by mid-bit sampling, and hands them to a receive buffer.
// Sticky framing/overrun flags are cleared by iClearErrors (a new error wins).
// Build option: UART_RX_FIFO_EN turns the buffer into a FIFO_DEPTH-entry FIFO.
module eprisc_uart_receiver
    import eprisc_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 256,
    parameter int FIFO_DEPTH   = 4
)(
    input  logic                      iBoardClock,
    input  logic                      iBoardReset,
    input  logic                      iSerialRX,
    output logic [UART_DATA_BITS-1:0] oData,
    output logic                      oValid,
    input  logic                      iReady,
    output logic                      oFramingError,
    output logic                      oOverrun,
    input  logic                      iClearErrors
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(UART_DATA_BITS - 1);

    if ((CLKS_PER_BIT % 2) != 0 || CLKS_PER_BIT < 8) begin : gBadClksPerBit
        $error("CLKS_PER_BIT must be even and at least 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadFifoDepth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end

    rx_state_t                 state;
    rx_state_t                 stateNext;
    logic                      rxsMeta;
    logic                      rxs;
    logic                      rxsPrev;
    logic [CNT_W-1:0]          timer;
    logic [CNT_W-1:0]          timerNext;
    logic [IDX_W-1:0]          bitIdx;
    logic [IDX_W-1:0]          bitIdxNext;
    logic [UART_DATA_BITS-1:0] shiftReg;
    logic [UART_DATA_BITS-1:0] shiftNext;
    logic                      pushByte;
    logic                      framingSet;
    logic                      fifoDrop;

    // Two-flop synchronizer for the asynchronous pin plus a delayed copy for edge detection.
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iBoardClock) begin
        if (iBoardReset) begin
            rxsMeta <= UART_IDLE_LEVEL;
            rxs     <= UART_IDLE_LEVEL;
            rxsPrev <= UART_IDLE_LEVEL;
        end else begin
            rxsMeta <= iSerialRX;
            rxs     <= rxsMeta;
            rxsPrev <= rxs;
        end
    end

    // Deframer state, bit timer, bit index and shift register.
    always_ff @(posedge iBoardClock) begin
        if (iBoardReset) begin
            state    <= IDLE;
            timer    <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else begin
            state    <= stateNext;
            timer    <= timerNext;
            bitIdx   <= bitIdxNext;
            shiftReg <= shiftNext;
        end
    end

    // Next-state logic: half a bit to the start-bit centre, then one bit period per sample.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        stateNext  = state;
        timerNext  = (timer == FULL_LAST) ? '0 : timer + 1'b1;
        bitIdxNext = bitIdx;
        shiftNext  = shiftReg;
        pushByte   = 1'b0;
        framingSet = 1'b0;
        unique case (state)
            IDLE: begin
                timerNext = '0;
                if (rxsPrev && !rxs) begin
                    bitIdxNext = '0;
                    stateNext  = START;
                end
            end
            START: begin
                if (timer == HALF_LAST) begin
                    timerNext = '0;
                    stateNext = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == FULL_LAST) begin
                    shiftNext  = {rxs, shiftReg[UART_DATA_BITS-1:1]};
                    bitIdxNext = bitIdx + 1'b1;
                    if (bitIdx == LAST_BIT) begin
                        stateNext = STOP;
                    end
                end
            end
            STOP: begin
                if (timer == FULL_LAST) begin
                    if (rxs == UART_IDLE_LEVEL) begin
                        pushByte  = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        framingSet = 1'b1;
                        stateNext  = BREAK;
                    end
                end
            end
            BREAK: begin
                timerNext = '0;
                if (rxs == UART_IDLE_LEVEL) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge iBoardClock) begin
        if (iBoardReset) begin
            oFramingError <= 1'b0;
            oOverrun      <= 1'b0;
        end else begin
            oFramingError <= framingSet | (oFramingError & ~iClearErrors);
            oOverrun      <= fifoDrop   | (oOverrun      & ~iClearErrors);
        end
    end

    eprisc_uart_rx_fifo
`ifdef UART_RX_FIFO_EN
    #(
        .DEPTH(FIFO_DEPTH)
    )
`endif
    uFifo (
        .iBoardClock(iBoardClock),
        .iBoardReset(iBoardReset),
        .iPush      (pushByte),
        .iPushData  (shiftReg),
        .oData      (oData),
        .oValid     (oValid),
        .iReady     (iReady),
        .oDrop      (fifoDrop)
    );

endmodule

// File: doc/eprisc_uart_receiver.md
# eprisc_uart_receiver

Asynchronous 8N1 serial receiver for the epRISC I/O controller. It converts the raw TTL serial RX pin into bytes and buffers them for the controller's register/bus logic through a valid/ready interface. The block sits directly downstream of the board's TTL serial pin and upstream of the controller's command decoder. It also reports framing and overrun errors.

## Interface
- CLKS_PER_BIT, 256: board clocks per serial bit. Must be even and ≥ 8.
- FIFO_DEPTH, 4: receive buffer entries. Must be a power of 2 and is only used with the FIFO macro.
- iBoardClock  in  1  board clock; all logic is on the rising edge.
- iBoardReset  in  1  synchronous, active-high reset.
- iSerialRX  in  1  asynchronous serial line; idle is high.
- oData  out  8  byte at the buffer head.
- oValid  out  1  buffer is non-empty.
- iReady  in  1  consumer pop; the buffer pops when oValid && iReady.
- oFramingError  out  1  sticky; the stop bit was sampled low.
- oOverrun  out  1  sticky; a completed byte was dropped because the buffer was full.
- iClearErrors  in  1  one-cycle pulse that clears both sticky flags.

## Operation
- **Input synchronizer:** iSerialRX passes through a 2-flop synchronizer (rxs). Both flops reset to 1.
- **State machine:** IDLE, START, DATA, STOP, BREAK.
- **IDLE:** on a rxs falling edge (previous 1, current 0), clear the bit counter and go to START.
- **START:** wait CLKS_PER_BIT/2 cycles, then sample rxs.
  - Sample = 1: false start; return to IDLE with no flags set.
  - Sample = 0: go to DATA.
- **DATA:** sample rxs every CLKS_PER_BIT cycles, 8 samples total. Shift in LSB first. After bit 7, go to STOP.
- **STOP:** sample rxs CLKS_PER_BIT cycles after bit 7.
  - Sample = 1: push the byte and return to IDLE.
  - Sample = 0: set oFramingError, discard the byte, go to BREAK.
- **BREAK:** stay until rxs = 1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- **Push into a full buffer:** the byte is dropped and oOverrun is set.
  - If a pop occurs in the same cycle as the push, the push is accepted and oOverrun is not set.
- **Push and pop in the same cycle (not full):** both take effect and the occupancy is unchanged.
- **Flag clear vs. set:** iClearErrors clears the flags. If a new error is detected in the same cycle, the set wins.
- **oData:** undefined when oValid = 0 (drives the last slot contents).

## Timing
- **Reset values:** oData = 0, oValid = 0, oFramingError = 0, oOverrun = 0. State = IDLE, buffer empty, counters 0.
- **Reset mid-frame:** aborts the frame and discards any partial byte.
- **Sample points:** let t0 be the cycle in which the falling edge is seen on rxs (pin edge + 2 cycles).
  - Start sample at t0 + CLKS_PER_BIT/2.
  - Data bit i sample at t0 + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
  - Stop sample at t0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- **Output latency:** oValid rises on the cycle after the stop sample. With the default, that is 2435 cycles after the pin falling edge.
- **Buffer output:** oData/oValid are registered. After a pop, the next entry appears on the following cycle.
- **Tolerance:** a baud mismatch of up to ±3% must be accepted.
- **Bit counter width:** $clog2(CLKS_PER_BIT). The counter wraps to 0 at CLKS_PER_BIT−1.

## Configuration
- **UART_RX_FIFO_EN defined:** the buffer is a circular FIFO of FIFO_DEPTH entries.
  - Read/write pointers are $clog2(FIFO_DEPTH)+1 bits; the MSB distinguishes full from empty.
- **UART_RX_FIFO_EN undefined:** the buffer is a single holding register (depth 1), with identical handshake, overrun and simultaneous push/pop rules.

## Structure
- **Package eprisc_uart_pkg:**
  - rx_state_t enum (IDLE, START, DATA, STOP, BREAK).
  - UART_DATA_BITS = 8.
  - UART_IDLE_LEVEL = 1'b1.
- **Sub-module eprisc_uart_rx_fifo:**
  - Contains the buffer storage, pointers and full/empty logic.
  - Has a push/data-in port and exposes oData/oValid/iReady.
  - The macro selects its implementation.
- The top level holds the synchronizer, state machine, counters and error flags.

## Test plan
- **Single byte:** 0x4E frame at 256 clocks/bit, iReady = 0 → oValid rises exactly 2435 cycles after the pin falling edge, oData = 0x4E, both flags 0.
- **Glitch rejection:** 50-cycle low pulse on an idle line → no push, state back to IDLE, flags 0.
- **Framing error:**
  - Stimulus: 0x00 frame with stop bit low, line held low 3000 cycles, then high.
  - Required: oFramingError = 1, no byte pushed, no further frames while low.
  - After an iClearErrors pulse, oFramingError = 0.
- **Overrun (FIFO enabled), iReady = 0:** frames 0x01–0x05 → oOverrun = 1 after the fifth frame. Popping yields 0x01, 0x02, 0x03, 0x04, then oValid = 0.
- **Push/pop when full:** buffer full, iReady = 1 held in the cycle a 0x5A push completes → no overrun, 0x5A is delivered last.
- **Reset mid-frame:** iBoardReset pulsed during data bit 3 → all outputs 0 next cycle. A following 0xA5 frame is received correctly.
